// File: rtl/mycpu_id_stage.sv
// MIPS32 instruction-decode stage: ID pipeline register, 32x32 register file with write-through,
// operand forwarding, load-use stall and branch/jump resolution. Build option: MYCPU_ID_BYPASS_EN.
module mycpu_id_stage #(
    parameter int          NFWD     = 3,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fs_to_ds_valid,
    input  logic [31:0]         fs_pc,
    input  logic [31:0]         fs_inst,
    output logic                ds_allowin,
    input  logic                es_allowin,
    output logic                ds_to_es_valid,
    output logic [31:0]         ds_pc,
    output logic [3:0]          ds_aluop,
    output logic [31:0]         ds_src_a,
    output logic [31:0]         ds_src_b,
    output logic [31:0]         ds_store_data,
    output logic [4:0]          ds_dest,
    output logic                ds_rf_we,
    output logic [5:0]          ds_mem_ctrl,
    output logic                br_taken,
    output logic [31:0]         br_target,
    input  logic                ws_rf_we,
    input  logic [4:0]          ws_rf_waddr,
    input  logic [31:0]         ws_rf_wdata,
    input  logic [NFWD-1:0]     fwd_valid,
    input  logic [5*NFWD-1:0]   fwd_dest,
    input  logic [32*NFWD-1:0]  fwd_data,
    input  logic [NFWD-1:0]     fwd_pending
);

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_ADD  = 4'b1100;
    localparam logic [3:0] ALU_SUB  = 4'b1101;

    typedef enum logic [1:0] {A_RS, A_SA, A_PC, A_ZERO} aSel_e;
    typedef enum logic [2:0] {B_RT, B_SIMM, B_ZIMM, B_LUI, B_EIGHT} bSel_e;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_GEZ, BR_GTZ, BR_LEZ, BR_LTZ, BR_JUMP} brCond_e;
    typedef enum logic [1:0] {T_REL, T_IDX, T_REG} tgtSel_e;

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] rf_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] jIndex;

    logic        useRs, useRt, rAlu, iAlu, ld, st, link;
    logic [3:0]  aluop, shiftOp;
    aSel_e       aSel;
    bSel_e       bSel;
    brCond_e     brCond;
    tgtSel_e     tgtSel;
    logic [4:0]  dest;
    logic        rfWe;
    logic [5:0]  memCtrl;

    logic        rsHit, rtHit, rsPend, rtPend;
    logic [31:0] rsFwdData, rtFwdData, rfRs, rfRt, rsVal, rtVal;
    logic        rsStall, rtStall, stall, dsReadyGo, taken;
    logic [31:0] srcA, srcB, pcPlus4, target;

    assign opcode = inst_q[31:26];
    assign rs     = inst_q[25:21];
    assign rt     = inst_q[20:16];
    assign rd     = inst_q[15:11];
    assign sa     = inst_q[10:6];
    assign funct  = inst_q[5:0];
    assign imm    = inst_q[15:0];
    assign jIndex = inst_q[25:0];

    assign dsReadyGo      = !stall;
    assign ds_allowin     = !valid_q || (dsReadyGo && es_allowin);
    assign ds_to_es_valid = valid_q && dsReadyGo;
    assign ds_pc          = pc_q;

    // A new instruction takes priority; otherwise the slot empties once EX accepts it.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (fs_to_ds_valid && ds_allowin) begin
            valid_d = 1'b1;
            pc_d    = fs_pc;
            inst_d  = fs_inst;
        end else if (ds_to_es_valid && es_allowin) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (ws_rf_we && ws_rf_waddr != 5'd0) begin
            rf_q[ws_rf_waddr] <= ws_rf_wdata;
        end
    end

    // Register file reads see a same-cycle writeback; r0 is hardwired to zero.
    always_comb begin
        rfRs = rf_q[rs];
        rfRt = rf_q[rt];
        if (ws_rf_we && ws_rf_waddr == rs) rfRs = ws_rf_wdata;
        if (ws_rf_we && ws_rf_waddr == rt) rfRt = ws_rf_wdata;
        if (rs == 5'd0) rfRs = '0;
        if (rt == 5'd0) rfRt = '0;
    end

    always_comb begin
        useRs   = 1'b0;
        useRt   = 1'b0;
        rAlu    = 1'b0;
        iAlu    = 1'b0;
        ld      = 1'b0;
        st      = 1'b0;
        link    = 1'b0;
        aluop   = ALU_ADDU;
        aSel    = A_RS;
        bSel    = B_RT;
        dest    = 5'd0;
        rfWe    = 1'b0;
        memCtrl = 6'd0;
        brCond  = BR_NONE;
        tgtSel  = T_REL;
        shiftOp = (funct[1:0] == 2'b00) ? ALU_SLL : (funct[0] ? ALU_SRA : ALU_SRL);
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b000000, 6'b000010, 6'b000011: begin
                        aluop = shiftOp;
                        aSel  = A_SA;
                        useRt = 1'b1;
                        dest  = rd;
                        rfWe  = 1'b1;
                    end
                    6'b000100, 6'b000110, 6'b000111: begin rAlu = 1'b1; aluop = shiftOp; end
                    6'b001000: begin useRs = 1'b1; brCond = BR_JUMP; tgtSel = T_REG; end
                    6'b001001: begin
                        useRs  = 1'b1;
                        brCond = BR_JUMP;
                        tgtSel = T_REG;
                        link   = 1'b1;
                        dest   = rd;
                    end
                    6'b100000: begin rAlu = 1'b1; aluop = ALU_ADD;  end
                    6'b100001: begin rAlu = 1'b1; aluop = ALU_ADDU; end
                    6'b100010: begin rAlu = 1'b1; aluop = ALU_SUB;  end
                    6'b100011: begin rAlu = 1'b1; aluop = ALU_SUBU; end
                    6'b100100: begin rAlu = 1'b1; aluop = ALU_AND;  end
                    6'b100101: begin rAlu = 1'b1; aluop = ALU_OR;   end
                    6'b100110: begin rAlu = 1'b1; aluop = ALU_XOR;  end
                    6'b100111: begin rAlu = 1'b1; aluop = ALU_NOR;  end
                    6'b101010: begin rAlu = 1'b1; aluop = ALU_SLT;  end
                    6'b101011: begin rAlu = 1'b1; aluop = ALU_SLTU; end
                    default: ;
                endcase
            end
            6'b000001: begin
                useRs = 1'b1;
                case (rt)
                    5'b00000: brCond = BR_LTZ;
                    5'b00001: brCond = BR_GEZ;
                    5'b10000: begin brCond = BR_LTZ; link = 1'b1; dest = 5'd31; end
                    5'b10001: begin brCond = BR_GEZ; link = 1'b1; dest = 5'd31; end
                    default: useRs = 1'b0;
                endcase
            end
            6'b000010: begin brCond = BR_JUMP; tgtSel = T_IDX; end
            6'b000011: begin brCond = BR_JUMP; tgtSel = T_IDX; link = 1'b1; dest = 5'd31; end
            6'b000100: begin useRs = 1'b1; useRt = 1'b1; brCond = BR_EQ; end
            6'b000101: begin useRs = 1'b1; useRt = 1'b1; brCond = BR_NE; end
            6'b000110: begin useRs = 1'b1; brCond = BR_LEZ; end
            6'b000111: begin useRs = 1'b1; brCond = BR_GTZ; end
            6'b001000: begin iAlu = 1'b1; bSel = B_SIMM; aluop = ALU_ADD;  end
            6'b001001: begin iAlu = 1'b1; bSel = B_SIMM; aluop = ALU_ADDU; end
            6'b001010: begin iAlu = 1'b1; bSel = B_SIMM; aluop = ALU_SLT;  end
            6'b001011: begin iAlu = 1'b1; bSel = B_SIMM; aluop = ALU_SLTU; end
            6'b001100: begin iAlu = 1'b1; bSel = B_ZIMM; aluop = ALU_AND;  end
            6'b001101: begin iAlu = 1'b1; bSel = B_ZIMM; aluop = ALU_OR;   end
            6'b001110: begin iAlu = 1'b1; bSel = B_ZIMM; aluop = ALU_XOR;  end
            6'b001111: begin aSel = A_ZERO; bSel = B_LUI; dest = rt; rfWe = 1'b1; end
            6'b100000: begin ld = 1'b1; memCtrl = 6'b010001; end
            6'b100001: begin ld = 1'b1; memCtrl = 6'b010011; end
            6'b100010: begin ld = 1'b1; useRt = 1'b1; memCtrl = 6'b010110; end
            6'b100011: begin ld = 1'b1; memCtrl = 6'b010100; end
            6'b100100: begin ld = 1'b1; memCtrl = 6'b010000; end
            6'b100101: begin ld = 1'b1; memCtrl = 6'b010010; end
            6'b100110: begin ld = 1'b1; useRt = 1'b1; memCtrl = 6'b011000; end
            6'b101000: begin st = 1'b1; memCtrl = 6'b100000; end
            6'b101001: begin st = 1'b1; memCtrl = 6'b100010; end
            6'b101010: begin st = 1'b1; memCtrl = 6'b100110; end
            6'b101011: begin st = 1'b1; memCtrl = 6'b100100; end
            6'b101110: begin st = 1'b1; memCtrl = 6'b101000; end
            default: ;
        endcase
        if (rAlu) begin useRs = 1'b1; useRt = 1'b1; dest = rd; rfWe = 1'b1; end
        if (iAlu || ld) begin useRs = 1'b1; dest = rt; rfWe = 1'b1; end
        if (ld) bSel = B_SIMM;
        if (st) begin useRs = 1'b1; useRt = 1'b1; bSel = B_SIMM; end
        if (link) begin aSel = A_PC; bSel = B_EIGHT; aluop = ALU_ADDU; rfWe = 1'b1; end
    end

    // Scan from the oldest source down so the youngest matching source wins.
    always_comb begin
        rsHit     = 1'b0;
        rsPend    = 1'b0;
        rsFwdData = '0;
        rtHit     = 1'b0;
        rtPend    = 1'b0;
        rtFwdData = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_dest[i*5 +: 5] == rs && rs != 5'd0) begin
                rsHit     = 1'b1;
                rsPend    = fwd_pending[i];
                rsFwdData = fwd_data[i*32 +: 32];
            end
            if (fwd_valid[i] && fwd_dest[i*5 +: 5] == rt && rt != 5'd0) begin
                rtHit     = 1'b1;
                rtPend    = fwd_pending[i];
                rtFwdData = fwd_data[i*32 +: 32];
            end
        end
    end

`ifdef MYCPU_ID_BYPASS_EN
    assign rsVal   = rsHit ? rsFwdData : rfRs;
    assign rtVal   = rtHit ? rtFwdData : rfRt;
    assign rsStall = useRs && rsHit && rsPend;
    assign rtStall = useRt && rtHit && rtPend;
`else
    logic unusedFwd;
    assign unusedFwd = ^{rsPend, rtPend, rsFwdData, rtFwdData};
    assign rsVal   = rfRs;
    assign rtVal   = rfRt;
    assign rsStall = useRs && rsHit;
    assign rtStall = useRt && rtHit;
`endif

    assign stall   = valid_q && (rsStall || rtStall);
    assign pcPlus4 = pc_q + 32'd4;

    always_comb begin
        taken  = 1'b0;
        srcA   = rsVal;
        srcB   = rtVal;
        target = pcPlus4 + {{14{imm[15]}}, imm, 2'b00};
        case (brCond)
            BR_EQ:   taken = (rsVal == rtVal);
            BR_NE:   taken = (rsVal != rtVal);
            BR_GEZ:  taken = !rsVal[31];
            BR_GTZ:  taken = !rsVal[31] && (rsVal != 32'd0);
            BR_LEZ:  taken = rsVal[31] || (rsVal == 32'd0);
            BR_LTZ:  taken = rsVal[31];
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        case (tgtSel)
            T_IDX:   target = {pcPlus4[31:28], jIndex, 2'b00};
            T_REG:   target = rsVal;
            default: ;
        endcase
        case (aSel)
            A_SA:    srcA = {27'b0, sa};
            A_PC:    srcA = pc_q;
            A_ZERO:  srcA = '0;
            default: ;
        endcase
        case (bSel)
            B_SIMM:  srcB = {{16{imm[15]}}, imm};
            B_ZIMM:  srcB = {16'h0, imm};
            B_LUI:   srcB = {imm, 16'h0};
            B_EIGHT: srcB = 32'd8;
            default: ;
        endcase
    end

    assign ds_aluop      = ds_to_es_valid ? aluop   : 4'd0;
    assign ds_src_a      = ds_to_es_valid ? srcA    : 32'd0;
    assign ds_src_b      = ds_to_es_valid ? srcB    : 32'd0;
    assign ds_store_data = ds_to_es_valid ? rtVal   : 32'd0;
    assign ds_dest       = ds_to_es_valid ? dest    : 5'd0;
    assign ds_rf_we      = ds_to_es_valid && rfWe;
    assign ds_mem_ctrl   = ds_to_es_valid ? memCtrl : 6'd0;
    assign br_taken      = ds_to_es_valid && es_allowin && taken;
    assign br_target     = ds_to_es_valid ? target  : 32'd0;

endmodule
